// File: rtl/brick_wall.sv
// brick_wall: breakout brick field with a pixel renderer and a
// one-brick-per-cycle collision scanner driven by frame_tick.
// Ports:
//   clock, reset (async, active low), start (rebuild on rising edge),
//   frame_tick (start a scan), x_ball/y_ball (ball centre),
//   next_x/next_y (pixel being rendered) ->
//   brick_pixel/brick_row (1-cycle latency), hit_brick/bounce_y (hit
//   pulse and bounce axis), bricks_left, cleared, busy.
module brick_wall #(
    parameter int ROWS    = 4,
    parameter int COLS    = 8,
    parameter int BRICK_W = 64,
    parameter int BRICK_H = 16,
    parameter int GAP     = 4,
    parameter int X0      = 48,
    parameter int Y0      = 40,
    parameter int R_BALL  = 8,
    localparam int RW     = (ROWS > 1) ? $clog2(ROWS) : 1
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          start,
    input  logic          frame_tick,
    input  logic [9:0]    x_ball,
    input  logic [9:0]    y_ball,
    input  logic [9:0]    next_x,
    input  logic [9:0]    next_y,
    output logic          brick_pixel,
    output logic [RW-1:0] brick_row,
    output logic          hit_brick,
    output logic          bounce_y,
    output logic [7:0]    bricks_left,
    output logic          cleared,
    output logic          busy
);

    localparam int N  = ROWS * COLS;
    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;

    localparam logic [10:0] BW1 = 11'(BRICK_W - 1);
    localparam logic [10:0] BH1 = 11'(BRICK_H - 1);
    localparam logic [10:0] RB  = 11'(R_BALL);

    typedef enum logic [1:0] {IDLE, SCAN, HIT} state_t;

    function automatic logic [10:0] col_x(input int c);
        return 11'(X0 + c * (BRICK_W + GAP));
    endfunction

    function automatic logic [10:0] row_y(input int r);
        return 11'(Y0 + r * (BRICK_H + GAP));
    endfunction

    state_t        state_q;
    logic [N-1:0]  alive_q;
    logic [7:0]    left_q;
    logic [7:0]    i_q;
    logic [RW-1:0] row_q;
    logic [CW-1:0] col_q;
    logic [9:0]    xb_q;
    logic [9:0]    yb_q;
    logic          start_q;
    logic          hit_q;
    logic          bnc_q;
    logic          pix_q;
    logic [RW-1:0] prow_q;

    // ---------------- pixel renderer ----------------
    logic [10:0]   px;
    logic [10:0]   py;
    logic          pix_d;
    logic [RW-1:0] prow_d;

    assign px = {1'b0, next_x};
    assign py = {1'b0, next_y};

    always_comb begin
        pix_d  = 1'b0;
        prow_d = '0;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                if (alive_q[r*COLS+c] &&
                    px >= col_x(c) && px <= col_x(c) + BW1 &&
                    py >= row_y(r) && py <= row_y(r) + BH1) begin
                    pix_d  = 1'b1;
                    prow_d = RW'(r);
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pix_q  <= 1'b0;
            prow_q <= '0;
        end else begin
            pix_q  <= pix_d;
            prow_q <= prow_d;
        end
    end

    // ---------------- collision scanner ----------------
    logic [10:0]  xc;
    logic [10:0]  yc;
    logic [10:0]  xl;
    logic [10:0]  xh;
    logic [10:0]  yl;
    logic [10:0]  yh;
    logic [10:0]  sx;
    logic [10:0]  sy;
    logic [N-1:0] kill_d;
    logic         overlap_d;
    logic         hit_d;
    logic         bounce_d;
    logic         start_edge;
    logic         last_d;

    assign xc = {1'b0, xb_q};
    assign yc = {1'b0, yb_q};
    // Lower box edges clamp at the screen origin.
    assign xl = (xc >= RB) ? xc - RB : '0;
    assign yl = (yc >= RB) ? yc - RB : '0;
    assign xh = xc + RB;
    assign yh = yc + RB;
    assign sx = col_x(int'(col_q));
    assign sy = row_y(int'(row_q));

    always_comb begin
        kill_d    = '0;
        kill_d[0] = 1'b1;
        kill_d    = kill_d << i_q;
    end

    assign overlap_d  = (sx <= xh) && (sx + BW1 >= xl) &&
                        (sy <= yh) && (sy + BH1 >= yl);
    assign hit_d      = (state_q == SCAN) && |(alive_q & kill_d) &&
                        overlap_d;
    // Centre inside the brick's columns means a top/bottom strike.
    assign bounce_d   = (xc >= sx) && (xc <= sx + BW1);
    assign start_edge = start & ~start_q;
    assign last_d     = (i_q == 8'(N - 1));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            alive_q <= '1;
            left_q  <= 8'(N);
            i_q     <= '0;
            row_q   <= '0;
            col_q   <= '0;
            xb_q    <= '0;
            yb_q    <= '0;
            start_q <= 1'b0;
            hit_q   <= 1'b0;
            bnc_q   <= 1'b0;
        end else begin
            start_q <= start;
            hit_q   <= 1'b0;
            if (start_edge) begin
                state_q <= IDLE;
                alive_q <= '1;
                left_q  <= 8'(N);
                i_q     <= '0;
                row_q   <= '0;
                col_q   <= '0;
            end else begin
                unique case (state_q)
                    IDLE: begin
                        if (frame_tick) begin
                            xb_q    <= x_ball;
                            yb_q    <= y_ball;
                            i_q     <= '0;
                            row_q   <= '0;
                            col_q   <= '0;
                            state_q <= SCAN;
                        end
                    end
                    SCAN: begin
                        if (hit_d) begin
                            alive_q <= alive_q & ~kill_d;
                            left_q  <= left_q - 8'd1;
                            bnc_q   <= bounce_d;
                            hit_q   <= 1'b1;
                            state_q <= HIT;
                        end else if (last_d) begin
                            state_q <= IDLE;
                        end else begin
                            i_q <= i_q + 8'd1;
                            if (int'(col_q) == COLS - 1) begin
                                col_q <= '0;
                                row_q <= row_q + 1'b1;
                            end else begin
                                col_q <= col_q + 1'b1;
                            end
                        end
                    end
                    HIT: begin
                        state_q <= IDLE;
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

    assign brick_pixel = pix_q;
    assign brick_row   = prow_q;
    assign hit_brick   = hit_q;
    assign bounce_y    = bnc_q;
    assign bricks_left = left_q;
    assign cleared     = (left_q == 8'd0);
    assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_brick_wall.sv
// tb_brick_wall: pixel vector table plus hit scoreboard for brick_wall,
// and a 1x2 instance for the clear/rebuild corner case.
module tb_brick_wall;

    localparam int ROWS = 4;
    localparam int COLS = 8;
    localparam int N    = ROWS * COLS;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       frame_tick = 1'b0;
    logic [9:0] x_ball = '0;
    logic [9:0] y_ball = '0;
    logic [9:0] next_x = '0;
    logic [9:0] next_y = '0;
    logic       brick_pixel;
    logic [1:0] brick_row;
    logic       hit_brick;
    logic       bounce_y;
    logic [7:0] bricks_left;
    logic       cleared;
    logic       busy;

    logic       s_start = 1'b0;
    logic       s_tick = 1'b0;
    logic [9:0] s_x = '0;
    logic [9:0] s_y = '0;
    logic [9:0] s_nx = '0;
    logic [9:0] s_ny = '0;
    logic       s_pix;
    logic [0:0] s_row;
    logic       s_hit;
    logic       s_bnc;
    logic [7:0] s_left;
    logic       s_clr;
    logic       s_busy;

    always #5 clock = ~clock;

    brick_wall dut (
        .clock(clock), .reset(reset), .start(start),
        .frame_tick(frame_tick),
        .x_ball(x_ball), .y_ball(y_ball),
        .next_x(next_x), .next_y(next_y),
        .brick_pixel(brick_pixel), .brick_row(brick_row),
        .hit_brick(hit_brick), .bounce_y(bounce_y),
        .bricks_left(bricks_left), .cleared(cleared), .busy(busy)
    );

    brick_wall #(.ROWS(1), .COLS(2)) sdut (
        .clock(clock), .reset(reset), .start(s_start),
        .frame_tick(s_tick),
        .x_ball(s_x), .y_ball(s_y),
        .next_x(s_nx), .next_y(s_ny),
        .brick_pixel(s_pix), .brick_row(s_row),
        .hit_brick(s_hit), .bounce_y(s_bnc),
        .bricks_left(s_left), .cleared(s_clr), .busy(s_busy)
    );

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;
    int s_hits = 0;

    typedef struct {
        int   at;
        logic by;
    } exp_t;

    typedef struct {
        int   x;
        int   y;
        logic pix;
        int   row;
    } vec_t;

    exp_t sbq[$];
    exp_t e;
    bit   alive_m [N];
    int   left_m;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    function automatic void rebuild();
        for (int i = 0; i < N; i++) alive_m[i] = 1'b1;
        left_m = N;
    endfunction

    function automatic void model_find(input int x, input int y,
                                       output int idx, output logic by);
        int xl, yl, bx, byy;
        xl  = (x < 8) ? 0 : x - 8;
        yl  = (y < 8) ? 0 : y - 8;
        idx = -1;
        by  = 1'b0;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                bx  = 48 + c * 68;
                byy = 40 + r * 20;
                if (idx < 0 && alive_m[r*COLS+c] &&
                    bx <= x + 8 && bx + 63 >= xl &&
                    byy <= y + 8 && byy + 15 >= yl) begin
                    idx = r * COLS + c;
                    by  = (x >= bx && x <= bx + 63);
                end
            end
        end
    endfunction

    function automatic void model_pix(input int x, input int y,
                                      output logic p, output int row);
        p   = 1'b0;
        row = 0;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                if (alive_m[r*COLS+c] &&
                    x >= 48 + c * 68 && x <= 48 + c * 68 + 63 &&
                    y >= 40 + r * 20 && y <= 40 + r * 20 + 15) begin
                    p   = 1'b1;
                    row = r;
                end
    endfunction

    task automatic pix_model_chk(input int x, input int y);
        logic p;
        int   row;
        next_x = 10'(x);
        next_y = 10'(y);
        step();
        model_pix(x, y, p, row);
        chk($sformatf("pix_%0d_%0d", x, y), brick_pixel, p);
        chk($sformatf("row_%0d_%0d", x, y), brick_row, row);
    endtask

    task automatic drain(input string nm, input int maxc);
        int n = 0;
        while ((sbq.size() != 0 || busy) && n < maxc) begin
            step();
            n++;
        end
        step();
        chk({"drain_", nm}, sbq.size(), 0);
    endtask

    task automatic frame(input int x, input int y);
        int   idx;
        logic by;
        exp_t ex;
        x_ball = 10'(x);
        y_ball = 10'(y);
        model_find(x, y, idx, by);
        if (idx >= 0) begin
            ex.at = cyc + idx + 2;
            ex.by = by;
            sbq.push_back(ex);
            alive_m[idx] = 1'b0;
            left_m--;
        end
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        drain($sformatf("%0d_%0d", x, y), N + 8);
        chk($sformatf("left_%0d_%0d", x, y), bricks_left, left_m);
    endtask

    // Scoreboard consumer: every hit pulse must match the queue head.
    always begin
        @(posedge clock);
        cyc++;
        #1;
        if (hit_brick) begin
            if (sbq.size() == 0) begin
                n_chk++;
                $display("FAIL hit_unexpected: hit_brick=1 at cycle %0d, expected none",
                         cyc);
            end else begin
                e = sbq.pop_front();
                chk("hit_cycle", cyc, e.at);
                chk("bounce_y", bounce_y, e.by);
            end
        end
    end

    always begin
        @(posedge clock);
        #1;
        if (s_hit) s_hits++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    vec_t vt [9];
    int   bcnt;

    initial begin
        vt[0] = '{48, 40, 1'b1, 0};
        vt[1] = '{112, 40, 1'b0, 0};
        vt[2] = '{111, 55, 1'b1, 0};
        vt[3] = '{111, 56, 1'b0, 0};
        vt[4] = '{48, 60, 1'b1, 1};
        vt[5] = '{47, 40, 1'b0, 0};
        vt[6] = '{116, 100, 1'b1, 3};
        vt[7] = '{587, 115, 1'b1, 3};
        vt[8] = '{588, 115, 1'b0, 0};
        rebuild();

        // reset state
        repeat (3) step();
        chk("rst_pix", brick_pixel, 0);
        chk("rst_row", brick_row, 0);
        chk("rst_hit", hit_brick, 0);
        chk("rst_bnc", bounce_y, 0);
        chk("rst_busy", busy, 0);
        chk("rst_left", bricks_left, 32);
        chk("rst_clr", cleared, 0);
        chk("rst_sleft", s_left, 2);
        reset = 1'b1;
        step();

        // pixel table
        foreach (vt[k]) begin
            next_x = 10'(vt[k].x);
            next_y = 10'(vt[k].y);
            step();
            chk($sformatf("vpix_%0d_%0d", vt[k].x, vt[k].y),
                brick_pixel, vt[k].pix);
            chk($sformatf("vrow_%0d_%0d", vt[k].x, vt[k].y),
                brick_row, vt[k].row);
        end

        // index 8 hit, top/bottom bounce
        frame(80, 64);
        pix_model_chk(80, 64);

        // straddles bricks 0 and 1: one per frame
        frame(114, 50);
        frame(114, 50);
        frame(114, 50);
        pix_model_chk(60, 45);

        // miss: full scan, extra ticks while busy ignored
        x_ball = 10'd320;
        y_ball = 10'd400;
        frame_tick = 1'b1;
        bcnt = 0;
        for (int k = 0; k < 40; k++) begin
            step();
            if (k == 2) frame_tick = 1'b0;
            if (busy) bcnt++;
        end
        chk("miss_busy_cycles", bcnt, 32);
        chk("miss_busy_end", busy, 0);
        chk("miss_left", bricks_left, left_m);

        // start edge aborts a scan aimed at index 24
        x_ball = 10'd80;
        y_ball = 10'd104;
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        step();
        step();
        start = 1'b1;
        step();
        chk("abort_start_busy", busy, 0);
        rebuild();
        repeat (30) step();
        chk("abort_start_left", bricks_left, left_m);
        chk("abort_start_clr", cleared, 0);
        start = 1'b0;
        step();
        pix_model_chk(60, 45);

        // same abort through reset
        frame(80, 64);
        x_ball = 10'd80;
        y_ball = 10'd104;
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        step();
        step();
        reset = 1'b0;
        #1;
        chk("abort_rst_busy", busy, 0);
        chk("abort_rst_hit", hit_brick, 0);
        chk("abort_rst_left", bricks_left, 32);
        rebuild();
        step();
        step();
        reset = 1'b1;
        repeat (30) step();
        chk("abort_rst_left2", bricks_left, left_m);

        // resumes normally after reset
        frame(80, 64);

        // start wins over a simultaneous frame_tick
        start = 1'b1;
        frame_tick = 1'b1;
        x_ball = 10'd80;
        y_ball = 10'd64;
        step();
        frame_tick = 1'b0;
        chk("prio_busy", busy, 0);
        chk("prio_left", bricks_left, 32);
        rebuild();
        repeat (30) step();
        start = 1'b0;
        step();

        // 1x2 wall: clear, scan while cleared, rebuild
        s_x = 10'd114;
        s_y = 10'd50;
        s_tick = 1'b1;
        step();
        s_tick = 1'b0;
        repeat (5) step();
        chk("s_left1", s_left, 1);
        chk("s_hits1", s_hits, 1);
        s_tick = 1'b1;
        step();
        s_tick = 1'b0;
        repeat (5) step();
        chk("s_left0", s_left, 0);
        chk("s_clr1", s_clr, 1);
        chk("s_hits2", s_hits, 2);
        s_tick = 1'b1;
        step();
        s_tick = 1'b0;
        repeat (6) step();
        chk("s_hits_cleared", s_hits, 2);
        chk("s_left_cleared", s_left, 0);
        s_start = 1'b1;
        step();
        chk("s_left_rebuilt", s_left, 2);
        chk("s_clr_rebuilt", s_clr, 0);
        s_start = 1'b0;
        step();

        chk("sb_empty", sbq.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/brick_wall.md
BRICK_WALL -- requirements
Module: brick_wall

Interface
REQ-001 The block SHALL take parameter ROWS, default 4, as the number of brick rows.
REQ-002 The block SHALL take parameter COLS, default 8, as the number of brick columns; N = ROWS*COLS SHALL be at most 255.
REQ-003 The block SHALL take parameters BRICK_W, default 64, and BRICK_H, default 16, as the brick width and height in pixels.
REQ-004 The block SHALL take parameter GAP, default 4, as the pixel spacing between adjacent bricks.
REQ-005 The block SHALL take parameters X0, default 48, and Y0, default 40, as the top-left corner of brick 0.
REQ-006 The block SHALL take parameter R_BALL, default 8, as the ball radius.
REQ-007 clock  in  1  pixel clock; all state on posedge.
REQ-008 reset  in  1  asynchronous, active-low reset.
REQ-009 start  in  1  level; a rising edge rebuilds the wall.
REQ-010 frame_tick  in  1  one-cycle pulse per frame; triggers a collision scan.
REQ-011 x_ball, y_ball  in  10 each  ball centre.
REQ-012 next_x, next_y  in  10 each  pixel being rendered.
REQ-013 brick_pixel  out  1  registered; 1 = pixel lies on a live brick.
REQ-014 brick_row  out  clog2(ROWS)  registered row index of that pixel, used for colour; 0 when brick_pixel = 0.
REQ-015 hit_brick  out  1  one-cycle pulse when a brick is destroyed.
REQ-016 bounce_y  out  1  valid with hit_brick; 1 = invert vy, 0 = invert vx.
REQ-017 bricks_left  out  8  count of live bricks.
REQ-018 cleared  out  1  high when bricks_left = 0.
REQ-019 busy  out  1  high while the FSM is in SCAN or HIT.

Function
REQ-020 The block SHALL hold an N-bit alive map; brick index = row*COLS + col.
REQ-021 Brick (r,c) SHALL span x from X0+c*(BRICK_W+GAP) to that value plus BRICK_W-1, and y from Y0+r*(BRICK_H+GAP) to that value plus BRICK_H-1, inclusive.
REQ-022 All rectangle arithmetic SHALL use 11-bit unsigned values.
REQ-023 Ball-box bounds x_ball-R_BALL and y_ball-R_BALL SHALL saturate at 0.
REQ-024 brick_pixel and brick_row SHALL reflect next_x/next_y with exactly 1 cycle of latency.
REQ-025 Gap pixels and dead-brick pixels SHALL render 0.
REQ-026 The FSM SHALL have the states IDLE, SCAN and HIT.
REQ-027 In IDLE, frame_tick SHALL latch x_ball/y_ball into internal registers, set index i = 0 and enter SCAN.
REQ-028 In SCAN, the block SHALL test one brick per cycle, i = 0..N-1, against the latched ball box [x-R,x+R] x [y-R,y+R].
REQ-029 A brick SHALL count as hit when it is alive and overlaps the ball box inclusively.
REQ-030 On the first hit at index i, the block SHALL clear alive[i], decrement bricks_left and compute bounce_y in that same cycle, then enter HIT.
REQ-031 bounce_y SHALL be 1 when the latched centre x lies within the brick's x-span, and 0 otherwise.
REQ-032 If i = N-1 is tested with no hit, the FSM SHALL return to IDLE with no pulse.
REQ-033 At most one brick SHALL be destroyed per frame.
REQ-034 HIT SHALL last 1 cycle with hit_brick = 1, then return to IDLE.
REQ-035 The hit pulse for index i SHALL occur (i+2) cycles after frame_tick, so worst-case scan latency is N+1 cycles.
REQ-036 frame_tick SHALL be ignored while in SCAN or HIT.
REQ-037 cleared SHALL be combinational from bricks_left = 0.
REQ-038 A scan run while cleared = 1 SHALL find no hit.
REQ-039 On a registered rising edge of start, the block SHALL set alive to all ones, set bricks_left = N, force IDLE and suppress any pending hit_brick.
REQ-040 A start edge SHALL abort an active scan.
REQ-041 A start edge SHALL take priority over a frame_tick arriving in the same cycle.

Reset
REQ-042 While reset = 0, alive SHALL be all ones and bricks_left SHALL be N.
REQ-043 While reset = 0, the FSM SHALL be IDLE and i SHALL be 0.
REQ-044 While reset = 0, brick_pixel, brick_row, hit_brick, bounce_y and busy SHALL be 0.
REQ-045 While reset = 0, the start edge detector register SHALL be 0.
REQ-046 Reset asserted mid-scan SHALL abort immediately with no pulse.
REQ-047 The block SHALL resume on the first clock edge after reset deasserts.

Verification
REQ-048 Reset release, defaults -> bricks_left = 32, cleared = 0; pixel (48,40) gives brick_pixel = 1 and brick_row = 0 one cycle later; pixel (112,40) gives brick_pixel = 0.
REQ-049 Ball (80,64), frame_tick -> index 8 hit; hit_brick pulses 10 cycles after the tick with bounce_y = 1; bricks_left = 31; pixel (80,64) now renders 0.
REQ-050 Ball (114,50) -> only index 0 destroyed, with bounce_y = 0; bricks_left = 31; the next frame_tick destroys index 1.
REQ-051 Ball (320,400), frame_tick -> no hit_brick; busy high for 32 cycles, then 0; bricks_left unchanged.
REQ-052 ROWS = 1, COLS = 2, ball over both bricks, two ticks -> cleared = 1; a start rising edge then gives bricks_left = 2 and cleared = 0.
REQ-053 frame_tick followed by start rising edge 3 cycles later -> no hit_brick, busy = 0 next cycle, bricks_left = N; the same test repeated with reset asserted gives identical results.
